// File: rtl/row_access_scheduler.sv
// Row front-end: per-lane round-robin bank assignment for writes, RAW-hazard and
// credit gated lookup issue, and a write freeze that keeps a stalled lookup from starving.
module row_access_scheduler #(
  parameter int NUM_MUL      = 4,
  parameter int NUM_WR       = 8,
  parameter int INDEX_WIDTH  = 12,
  parameter int KEY_WIDTH    = 32,
  parameter int HAZ_DEPTH    = 3,
  parameter int CREDITS      = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WR-1:0]              wr_req_valid,
  input  logic [NUM_WR*INDEX_WIDTH-1:0]  wr_req_index,
  output logic [NUM_WR-1:0]              wr_req_ready,
  input  logic                           rd_req_valid,
  input  logic [INDEX_WIDTH-1:0]         rd_req_index,
  input  logic [KEY_WIDTH-1:0]           rd_req_key,
  input  logic [1:0]                     rd_req_opt,
  output logic                           rd_req_ready,
  input  logic                           rd_credit_return,
  output logic [NUM_WR*NUM_MUL-1:0]      arbiter_result,
  output logic [NUM_WR-1:0]              write_reg_0_valid,
  output logic [NUM_WR*INDEX_WIDTH-1:0]  write_reg_0_index,
  output logic [INDEX_WIDTH-1:0]         rd_index,
  output logic [KEY_WIDTH-1:0]           rd_key,
  output logic [1:0]                     rd_opt,
  output logic                           wr_freeze
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [NUM_WR*NUM_MUL-1:0] PTR_RESET = {NUM_WR{{(NUM_MUL-1){1'b0}}, 1'b1}};

  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

  function automatic logic [NUM_MUL-1:0] rotate_left(input logic [NUM_MUL-1:0] p);
    return {p[NUM_MUL-2:0], p[NUM_MUL-1]};
  endfunction

  state_t                          state_r, state_nxt_s;
  logic                            wr_ready_s, hazard_s, rd_ready_s, rd_issue_s, stall_inc_s;
  logic [NUM_WR-1:0]               wr_accept_s;
  logic [CW-1:0]                   credits_r, credits_nxt_s;
  logic [SW-1:0]                   stall_r, stall_nxt_s;
  logic [NUM_WR*NUM_MUL-1:0]       ptr_r, arb_r;
  logic [NUM_WR-1:0]               wr_vld_r;
  logic [NUM_WR*INDEX_WIDTH-1:0]   wr_idx_r;
  logic [INDEX_WIDTH-1:0]          rd_index_r;
  logic [KEY_WIDTH-1:0]            rd_key_r;
  logic [1:0]                      rd_opt_r;
  logic [NUM_WR-1:0]               hist_vld_r [HAZ_DEPTH];
  logic [NUM_WR*INDEX_WIDTH-1:0]   hist_idx_r [HAZ_DEPTH];

  // Handshakes, hazard detection and issue decision.
  always_comb begin
    wr_accept_s = wr_req_valid & {NUM_WR{wr_ready_s}};
    hazard_s    = 1'b0;
    for (int d = 0; d < HAZ_DEPTH; d++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        hazard_s = hazard_s | (hist_vld_r[d][i] &
                   (hist_idx_r[d][INDEX_WIDTH*i +: INDEX_WIDTH] == rd_req_index));
      end
    end
    for (int i = 0; i < NUM_WR; i++) begin
      hazard_s = hazard_s | (wr_accept_s[i] &
                 (wr_req_index[INDEX_WIDTH*i +: INDEX_WIDTH] == rd_req_index));
    end
    rd_ready_s  = reset & ~hazard_s & (credits_r != {CW{1'b0}});
    rd_issue_s  = rd_req_valid & rd_ready_s & (rd_req_opt != 2'b00);
    stall_inc_s = rd_req_valid & (rd_req_opt != 2'b00) & (credits_r != {CW{1'b0}}) & hazard_s;
  end

  // Credit and stall counter next values; credits saturate at CREDITS.
  always_comb begin
    credits_nxt_s = credits_r;
    stall_nxt_s   = stall_r;
    if (rd_issue_s && !rd_credit_return) begin
      credits_nxt_s = credits_r - CW'(1);
    end else if (!rd_issue_s && rd_credit_return && (credits_r != CW'(CREDITS))) begin
      credits_nxt_s = credits_r + CW'(1);
    end else begin
      credits_nxt_s = credits_r;
    end
    if (rd_issue_s || !rd_req_valid) begin
      stall_nxt_s = {SW{1'b0}};
    end else if (stall_inc_s && (stall_r != SW'(STARVE_LIMIT))) begin
      stall_nxt_s = stall_r + SW'(1);
    end else begin
      stall_nxt_s = stall_r;
    end
  end

  // Freeze FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= RUN;
    else        state_r <= state_nxt_s;
  end

  // Freeze FSM next state: freeze once the stall count saturates, release on issue.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if ((stall_r == SW'(STARVE_LIMIT)) && !rd_issue_s) state_nxt_s = FROZEN;
        else                                                state_nxt_s = RUN;
      end
      FROZEN: begin
        if (rd_issue_s) state_nxt_s = RUN;
        else            state_nxt_s = FROZEN;
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Freeze FSM outputs.
  always_comb begin
    wr_ready_s = 1'b0;
    case (state_r)
      RUN:     wr_ready_s = reset;
      FROZEN:  wr_ready_s = 1'b0;
      default: wr_ready_s = 1'b0;
    endcase
  end

  // Credit and stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_r <= CW'(CREDITS);
      stall_r   <= {SW{1'b0}};
    end else begin
      credits_r <= credits_nxt_s;
      stall_r   <= stall_nxt_s;
    end
  end

  // Write history of accepted indices, shifted every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < HAZ_DEPTH; d++) begin
        hist_vld_r[d] <= {NUM_WR{1'b0}};
        hist_idx_r[d] <= {(NUM_WR*INDEX_WIDTH){1'b0}};
      end
    end else begin
      hist_vld_r[0] <= wr_accept_s;
      hist_idx_r[0] <= wr_req_index;
      for (int d = 1; d < HAZ_DEPTH; d++) begin
        hist_vld_r[d] <= hist_vld_r[d-1];
        hist_idx_r[d] <= hist_idx_r[d-1];
      end
    end
  end

  // Bank pointers and the registered write bundle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r    <= PTR_RESET;
      arb_r    <= {(NUM_WR*NUM_MUL){1'b0}};
      wr_vld_r <= {NUM_WR{1'b0}};
      wr_idx_r <= {(NUM_WR*INDEX_WIDTH){1'b0}};
    end else begin
      wr_vld_r <= wr_accept_s;
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_accept_s[i]) begin
          arb_r[NUM_MUL*i +: NUM_MUL]             <= ptr_r[NUM_MUL*i +: NUM_MUL];
          ptr_r[NUM_MUL*i +: NUM_MUL]             <= rotate_left(ptr_r[NUM_MUL*i +: NUM_MUL]);
          wr_idx_r[INDEX_WIDTH*i +: INDEX_WIDTH] <= wr_req_index[INDEX_WIDTH*i +: INDEX_WIDTH];
        end else begin
          arb_r[NUM_MUL*i +: NUM_MUL]             <= {NUM_MUL{1'b0}};
          ptr_r[NUM_MUL*i +: NUM_MUL]             <= ptr_r[NUM_MUL*i +: NUM_MUL];
          wr_idx_r[INDEX_WIDTH*i +: INDEX_WIDTH] <= {INDEX_WIDTH{1'b0}};
        end
      end
    end
  end

  // Registered lookup issue bundle; all zero when nothing issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_index_r <= {INDEX_WIDTH{1'b0}};
      rd_key_r   <= {KEY_WIDTH{1'b0}};
      rd_opt_r   <= 2'b00;
    end else if (rd_issue_s) begin
      rd_index_r <= rd_req_index;
      rd_key_r   <= rd_req_key;
      rd_opt_r   <= rd_req_opt;
    end else begin
      rd_index_r <= {INDEX_WIDTH{1'b0}};
      rd_key_r   <= {KEY_WIDTH{1'b0}};
      rd_opt_r   <= 2'b00;
    end
  end

  assign wr_req_ready      = {NUM_WR{wr_ready_s}};
  assign rd_req_ready      = rd_ready_s;
  assign arbiter_result    = arb_r;
  assign write_reg_0_valid = wr_vld_r;
  assign write_reg_0_index = wr_idx_r;
  assign rd_index          = rd_index_r;
  assign rd_key            = rd_key_r;
  assign rd_opt            = rd_opt_r;
  assign wr_freeze         = (state_r == FROZEN);

endmodule

// File: tb/tb_row_access_scheduler.sv
// Scoreboard bench for row_access_scheduler: a cycle-level reference model predicts
// handshakes and queues expected output bundles; a negedge monitor compares them.
module tb_row_access_scheduler;
  localparam int NUM_MUL = 4, NUM_WR = 8, IW = 12, KW = 32;
  localparam int HAZ = 3, CRED = 8, SLIM = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic [NUM_WR-1:0] wr_req_valid, wr_req_ready, write_reg_0_valid;
  logic [NUM_WR*IW-1:0] wr_req_index, write_reg_0_index;
  logic rd_req_valid, rd_req_ready, rd_credit_return, wr_freeze;
  logic [IW-1:0] rd_req_index, rd_index;
  logic [KW-1:0] rd_req_key, rd_key;
  logic [1:0] rd_req_opt, rd_opt;
  logic [NUM_WR*NUM_MUL-1:0] arbiter_result;

  row_access_scheduler #(.NUM_MUL(NUM_MUL), .NUM_WR(NUM_WR), .INDEX_WIDTH(IW), .KEY_WIDTH(KW),
    .HAZ_DEPTH(HAZ), .CREDITS(CRED), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset(reset), .wr_req_valid(wr_req_valid), .wr_req_index(wr_req_index),
    .wr_req_ready(wr_req_ready), .rd_req_valid(rd_req_valid), .rd_req_index(rd_req_index),
    .rd_req_key(rd_req_key), .rd_req_opt(rd_req_opt), .rd_req_ready(rd_req_ready),
    .rd_credit_return(rd_credit_return), .arbiter_result(arbiter_result),
    .write_reg_0_valid(write_reg_0_valid), .write_reg_0_index(write_reg_0_index),
    .rd_index(rd_index), .rd_key(rd_key), .rd_opt(rd_opt), .wr_freeze(wr_freeze));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct { int due; logic [NUM_WR-1:0] vld; logic [NUM_WR*NUM_MUL-1:0] arb; logic [NUM_WR*IW-1:0] idx; } wr_exp_t;
  typedef struct { int due; logic [IW-1:0] idx; logic [KW-1:0] key; logic [1:0] opt; } rd_exp_t;
  typedef struct { int cyc; logic [IW-1:0] idx; } hist_t;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  hist_t   hist_q[$];
  int m_credits, m_stall, m_ptr[NUM_WR];
  bit m_freeze;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_WR*IW-1:0] put_idx(input int lane, input logic [IW-1:0] v);
    logic [NUM_WR*IW-1:0] r;
    r = '0;
    r[lane*IW +: IW] = v;
    return r;
  endfunction

  function automatic logic [NUM_WR*IW-1:0] lane_mask(input logic [NUM_WR-1:0] v);
    logic [NUM_WR*IW-1:0] m;
    for (int i = 0; i < NUM_WR; i++) m[i*IW +: IW] = {IW{v[i]}};
    return m;
  endfunction

  task automatic model_reset();
    m_credits = CRED; m_stall = 0; m_freeze = 1'b0;
    for (int i = 0; i < NUM_WR; i++) m_ptr[i] = 0;
    hist_q.delete(); wr_q.delete(); rd_q.delete();
  endtask

  // One clock cycle: drive, check handshakes against the model, queue expectations.
  task automatic drive_cycle(input logic [NUM_WR-1:0] wv, input logic [NUM_WR*IW-1:0] wi,
                             input logic rv, input logic [IW-1:0] ri, input logic [KW-1:0] rk,
                             input logic [1:0] ro, input logic ret, output logic acc);
    logic [NUM_WR-1:0] wacc;
    logic hz, rrdy, issue;
    int prev_stall;
    wr_exp_t we;
    rd_exp_t re;
    @(negedge clk);
    wr_req_valid = wv; wr_req_index = wi; rd_req_valid = rv; rd_req_index = ri;
    rd_req_key = rk; rd_req_opt = ro; rd_credit_return = ret;
    #1;
    check("wr_freeze", wr_freeze, m_freeze);
    check("wr_req_ready", wr_req_ready, m_freeze ? {NUM_WR{1'b0}} : {NUM_WR{1'b1}});
    wacc = m_freeze ? '0 : wv;
    while (hist_q.size() != 0 && (cyc - hist_q[0].cyc) > HAZ) void'(hist_q.pop_front());
    hz = 1'b0;
    foreach (hist_q[k]) if (hist_q[k].idx == ri) hz = 1'b1;
    for (int i = 0; i < NUM_WR; i++) if (wacc[i] && wi[i*IW +: IW] == ri) hz = 1'b1;
    rrdy = !hz && (m_credits != 0);
    check("rd_req_ready", rd_req_ready, rrdy);
    acc = rv && rrdy;
    issue = acc && (ro != 2'b00);
    if (wacc != '0) begin
      we.due = cyc + 1; we.vld = wacc; we.arb = '0; we.idx = '0;
      for (int i = 0; i < NUM_WR; i++) begin
        if (wacc[i]) begin
          we.arb[i*NUM_MUL +: NUM_MUL] = NUM_MUL'(1) << (m_ptr[i] % NUM_MUL);
          we.idx[i*IW +: IW] = wi[i*IW +: IW];
          m_ptr[i]++;
          hist_q.push_back('{cyc: cyc, idx: wi[i*IW +: IW]});
        end
      end
      wr_q.push_back(we);
    end
    if (issue) begin
      re.due = cyc + 1; re.idx = ri; re.key = rk; re.opt = ro;
      rd_q.push_back(re);
    end
    prev_stall = m_stall;
    if (issue || !rv) m_stall = 0;
    else if (ro != 2'b00 && m_credits != 0 && hz && m_stall < SLIM) m_stall++;
    if (issue) m_freeze = 1'b0;
    else if (prev_stall == SLIM) m_freeze = 1'b1;
    if (issue && !ret) m_credits--;
    else if (!issue && ret && m_credits < CRED) m_credits++;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) drive_cycle('0, '0, 1'b0, '0, '0, 2'b00, 1'b0, a);
  endtask

  task automatic refill();
    logic a;
    for (int k = 0; k < 20 && m_credits < CRED; k++) drive_cycle('0, '0, 1'b0, '0, '0, 2'b00, 1'b1, a);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_arbiter_result"}, arbiter_result, '0);
    check({tag, "_write_valid"}, write_reg_0_valid, '0);
    check({tag, "_write_index"}, write_reg_0_index, '0);
    check({tag, "_rd_index"}, rd_index, '0);
    check({tag, "_rd_key"}, rd_key, '0);
    check({tag, "_rd_opt"}, rd_opt, '0);
    check({tag, "_wr_freeze"}, wr_freeze, 1'b0);
    check({tag, "_wr_req_ready"}, wr_req_ready, '0);
    check({tag, "_rd_req_ready"}, rd_req_ready, 1'b0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a bundle, or one is overdue.
  wr_exp_t mw;
  rd_exp_t mr;
  always @(negedge clk) begin
    if (write_reg_0_valid != '0 || arbiter_result != '0) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected actual_valid=%0h expected=none (cycle %0d)", write_reg_0_valid, cyc);
      end else begin
        mw = wr_q.pop_front();
        check("wr_due_cycle", cyc, mw.due);
        check("write_reg_0_valid", write_reg_0_valid, mw.vld);
        check("arbiter_result", arbiter_result, mw.arb);
        check("write_reg_0_index", write_reg_0_index & lane_mask(mw.vld), mw.idx);
      end
    end else if (wr_q.size() != 0 && wr_q[0].due <= cyc) begin
      mw = wr_q.pop_front();
      check("write_reg_0_valid_missing", write_reg_0_valid, mw.vld);
    end
    if (rd_opt != 2'b00) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected actual_opt=%0h expected=none (cycle %0d)", rd_opt, cyc);
      end else begin
        mr = rd_q.pop_front();
        check("rd_due_cycle", cyc, mr.due);
        check("rd_index", rd_index, mr.idx);
        check("rd_key", rd_key, mr.key);
        check("rd_opt", rd_opt, mr.opt);
      end
    end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
      mr = rd_q.pop_front();
      check("rd_opt_missing", rd_opt, mr.opt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, p_v;
    logic [IW-1:0] p_idx;
    logic [KW-1:0] p_key;
    logic [1:0] p_opt;
    logic [NUM_WR*IW-1:0] wi;
    int n, k, freeze_at, acc_at;

    wr_req_valid = '0; wr_req_index = '0; rd_req_valid = 1'b0; rd_req_index = '0;
    rd_req_key = '0; rd_req_opt = 2'b00; rd_credit_return = 1'b0;
    model_reset();
    #3;
    check_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Bank rotation on lane 0.
    for (int j = 0; j < 5; j++) drive_cycle(8'h01, put_idx(0, IW'(12'h010 + j)), 1'b0, '0, '0, 2'b00, 1'b0, a);
    idle(HAZ + 1);

    // RAW hazard: read of the written index waits HAZ_DEPTH+1 cycles.
    n = 0; a = 1'b0;
    drive_cycle(8'h08, put_idx(3, 12'h055), 1'b1, 12'h055, 32'hA5A5_0001, 2'b01, 1'b0, a);
    while (!a && n < 20) begin
      n++;
      drive_cycle('0, '0, 1'b1, 12'h055, 32'hA5A5_0001, 2'b01, 1'b0, a);
    end
    check("raw_wait_cycles", n, HAZ + 1);
    idle(HAZ + 1);
    drive_cycle(8'h08, put_idx(3, 12'h055), 1'b1, 12'h056, 32'hA5A5_0002, 2'b01, 1'b0, a);
    check("raw_other_index_accept", a, 1'b1);

    // Credit exhaustion and return.
    refill();
    n = 0;
    for (int j = 0; j < 9; j++) begin
      drive_cycle('0, '0, 1'b1, IW'(12'h100 + j), 32'(j), 2'b10, 1'b0, a);
      n += int'(a);
    end
    check("credit_exhaust_issued", n, 8);
    check("ninth_blocked", a, 1'b0);
    drive_cycle('0, '0, 1'b1, 12'h108, 32'h8, 2'b10, 1'b1, a);
    check("ninth_with_return", a, 1'b0);
    drive_cycle('0, '0, 1'b1, 12'h108, 32'h8, 2'b10, 1'b0, a);
    check("ninth_after_return", a, 1'b1);
    idle(0);
    drive_cycle('0, '0, 1'b0, '0, '0, 2'b00, 1'b1, a);
    drive_cycle('0, '0, 1'b1, 12'h109, 32'h9, 2'b01, 1'b1, a);
    check("issue_with_return_at_1", a, 1'b1);
    drive_cycle('0, '0, 1'b1, 12'h10A, 32'hA, 2'b01, 1'b0, a);
    check("credit_still_1", a, 1'b1);
    drive_cycle('0, '0, 1'b1, 12'h10B, 32'hB, 2'b01, 1'b0, a);
    check("credit_now_0", a, 1'b0);
    refill();
    drive_cycle('0, '0, 1'b0, '0, '0, 2'b00, 1'b1, a);
    n = 0;
    for (int j = 0; j < 9; j++) begin
      drive_cycle('0, '0, 1'b1, IW'(12'h200 + j), 32'(j), 2'b11, 1'b0, a);
      n += int'(a);
    end
    check("saturated_credits_issued", n, 8);
    refill();
    idle(HAZ + 1);

    // Starvation: continuous writes to 7 against a pending read of 7.
    k = 0; a = 1'b0; freeze_at = -1; acc_at = -1;
    while (!a && k < 30) begin
      drive_cycle(8'h01, put_idx(0, 12'h007), 1'b1, 12'h007, 32'hBEEF, 2'b01, 1'b0, a);
      if (wr_freeze && freeze_at < 0) freeze_at = k;
      if (a) acc_at = k;
      k++;
    end
    check("starve_freeze_cycle", freeze_at, SLIM + 1);
    check("starve_accept_cycle", acc_at, SLIM + 1 + HAZ);
    idle(1);
    check("freeze_cleared", wr_freeze, 1'b0);

    // Randomized traffic with held lookups.
    p_v = 1'b0; p_idx = '0; p_key = '0; p_opt = 2'b00;
    for (int j = 0; j < 400; j++) begin
      if (!p_v && $urandom_range(0, 2) != 0) begin
        p_v = 1'b1; p_idx = IW'($urandom_range(0, 15)); p_key = $urandom; p_opt = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < NUM_WR; i++) wi[i*IW +: IW] = IW'($urandom_range(0, 15));
      drive_cycle(NUM_WR'($urandom & $urandom), wi, p_v, p_idx, p_key, p_opt,
                  ($urandom_range(0, 3) == 0), a);
      if (a) p_v = 1'b0;
    end
    for (int j = 0; j < 40 && p_v; j++) begin
      drive_cycle('0, '0, 1'b1, p_idx, p_key, p_opt, 1'b1, a);
      if (a) p_v = 1'b0;
    end
    idle(1);

    // Reset mid-burst: outputs clear without a clock edge.
    for (int i = 0; i < NUM_WR; i++) wi[i*IW +: IW] = IW'(12'h400 + i);
    drive_cycle(8'hFF, wi, 1'b1, 12'h3FF, 32'h1234_5678, 2'b01, 1'b0, a);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_zero("reset_mid");
    model_reset();
    @(negedge clk);
    wr_req_valid = '0; rd_req_valid = 1'b0; rd_credit_return = 1'b0;
    reset = 1'b1;
    for (int j = 0; j < 5; j++) drive_cycle(8'h01, put_idx(0, IW'(12'h020 + j)), 1'b0, '0, '0, 2'b00, 1'b0, a);
    n = 0;
    for (int j = 0; j < 9; j++) begin
      drive_cycle('0, '0, 1'b1, IW'(12'h500 + j), 32'(j), 2'b01, 1'b0, a);
      n += int'(a);
    end
    check("post_reset_credits", n, 8);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
